// File: rtl/usb_reg_responder.sv
// rtl/usb_reg_responder.sv - CW305 parallel USB bus to register-file strobe responder
//
// Purpose:
//   Turns host bus accesses (usb_cen/usb_rdn/usb_wrn, all in the usb_clk
//   domain) into single-cycle reg_read/reg_write strobes. The address and
//   byte index are frozen for the whole access. Read data is returned to
//   the pad tristate byte by byte.
//
// Ports:
//   usb_clk        in   host bus clock, sole clock
//   rst            in   synchronous active-high reset
//   usb_din        in   [7:0] bus data from the pad
//   usb_dout       out  [7:0] read data to the pad
//   usb_isout      out  pad output enable
//   usb_addr       in   [pADDR_WIDTH-1:0] host address
//   usb_rdn        in   active-low read
//   usb_wrn        in   active-low write
//   usb_cen        in   active-low chip select
//   reg_address    out  [pADDR_WIDTH-pBYTECNT_SIZE-1:0] register address
//   reg_bytecnt    out  [pBYTECNT_SIZE-1:0] byte index within the register
//   reg_datao      out  [7:0] write data to the register file
//   reg_datai      in   [7:0] read data, combinational from reg_address/reg_bytecnt
//   reg_read       out  one-cycle read strobe
//   reg_write      out  one-cycle write strobe
//   reg_addrvalid  out  access in progress

module usb_reg_responder #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                 usb_clk,
    input  logic                                 rst,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    input  logic [7:0]                           reg_datai,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    typedef enum logic [1:0] {
        ST_RELEASE = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t r_state;

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            r_state       <= ST_RELEASE;
            usb_dout      <= 8'h00;
            usb_isout     <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_datao     <= 8'h00;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
        end else begin
            // Strobes are single-cycle by default; only the IDLE entry of
            // an access raises one.
            reg_read  <= 1'b0;
            reg_write <= 1'b0;

            // Read data path runs independently of the FSM so the host can
            // hold rdn low and keep seeing valid data. A low wrn always
            // releases the bus so the pad never fights the host.
            if (!usb_rdn) begin
                usb_dout <= reg_datai;
            end
            usb_isout <= !usb_rdn && usb_wrn;

            case (r_state)
                ST_RELEASE: begin
                    // A select still low from before reset is ignored until
                    // the host has shown it high once.
                    reg_addrvalid <= 1'b0;
                    if (usb_cen) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (usb_cen) begin
                        reg_address   <= usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt   <= usb_addr[pBYTECNT_SIZE-1:0];
                        reg_addrvalid <= 1'b0;
                    end else begin
                        reg_addrvalid <= 1'b1;
                        if (!usb_wrn && usb_rdn) begin
                            reg_datao <= usb_din;
                            reg_write <= 1'b1;
                            r_state   <= ST_ACTIVE;
                        end else if (!usb_rdn && usb_wrn) begin
                            reg_read  <= 1'b1;
                            r_state   <= ST_ACTIVE;
                        end else if (!usb_rdn && !usb_wrn) begin
                            // Both strobes low: consume the select without
                            // touching the register file.
                            r_state   <= ST_ACTIVE;
                        end
                    end
                end

                ST_ACTIVE: begin
                    reg_addrvalid <= !usb_cen;
                    if (usb_cen) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state       <= ST_RELEASE;
                    reg_addrvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
